// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory arbiter.
//   - access width codes used by the load/store buffer
//   - arbiter state encoding and requester identity
//   - IO window base/mask and a width-to-byte-count helper
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_W_BYTE = 2'd0;
    localparam logic [1:0] MEM_W_HALF = 2'd1;
    localparam logic [1:0] MEM_W_WORD = 2'd2;

    localparam int MEM_STATE_WIDTH = 2;

    typedef enum logic [MEM_STATE_WIDTH-1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } mem_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // IO lives wherever addr[17:16] == 2'b11.
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam logic [31:0] IO_MASK         = 32'h0003_0000;

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            MEM_W_BYTE: width_bytes = 3'd1;
            MEM_W_HALF: width_bytes = 3'd2;
            MEM_W_WORD: width_bytes = 3'd4;
            default:    width_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port owner. Arbitrates between instruction fetch (word
// reads) and the load/store buffer (byte/half/word reads and writes), runs
// each access as consecutive single-byte RAM cycles, assembles/splits
// little-endian data and pulses a one-cycle ready to the owner.
//
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (global enable), flush
//   if_en/if_addr -> if_rdy/if_data           fetch requester
//   ls_en/ls_wr/ls_width/ls_addr/ls_wdata -> ls_rdy/ls_rdata   LSB
//   mem_din, mem_dout, mem_a, mem_wr          byte RAM port (1-cycle read)
//   io_buffer_full                            stalls writes into IO space
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        if_en,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_data,
    input  logic        ls_en,
    input  logic        ls_wr,
    input  logic [1:0]  ls_width,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_rdy,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mem_state_e  state, state_nxt;
    owner_e      last_grant, owner;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic [2:0]  cnt;

    logic        grant_if, grant_ls;
    logic [31:0] cur_addr;
    logic        stall;
    logic        rd_done, wr_done;
    logic [2:0]  cnt_m1;
    logic [31:0] data_nx;

    assign cur_addr = base + {29'd0, cnt};
    assign stall    = ((cur_addr & IO_MASK) == (IO_BASE & IO_MASK)) && io_buffer_full;
    // A read needs N+1 cycles: the last byte arrives one cycle after its address.
    assign rd_done  = (state == ST_READ) && !flush && (cnt == nbytes);
    assign wr_done  = (state == ST_WRITE) && !stall && (cnt == nbytes - 3'd1);
    // mem_din now holds the byte addressed last cycle, i.e. byte cnt-1.
    assign cnt_m1   = cnt - 3'd1;
    assign data_nx  = data | ({24'd0, mem_din} << {cnt_m1, 3'b000});

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= ST_IDLE;
        else if (rdy_in)
            state <= state_nxt;
    end

    // Next state and grant decision
    always_comb begin
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // No grant while a ready pulse is out: the requester still
                // holds en this cycle and would otherwise be granted twice.
                if (!flush && !if_rdy && !ls_rdy) begin
                    if (if_en && ls_en) begin
                        if (last_grant == OWN_IF) grant_ls = 1'b1;
                        else                      grant_if = 1'b1;
                    end else if (if_en) begin
                        grant_if = 1'b1;
                    end else if (ls_en) begin
                        grant_ls = 1'b1;
                    end
                end
                if (grant_if)      state_nxt = ST_READ;
                else if (grant_ls) state_nxt = ls_wr ? ST_WRITE : ST_READ;
            end
            ST_READ:  if (flush || rd_done) state_nxt = ST_IDLE;
            ST_WRITE: if (wr_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // RAM port outputs
    always_comb begin
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        case (state)
            ST_READ: if (cnt < nbytes) mem_a = cur_addr;
            ST_WRITE: begin
                mem_a    = cur_addr;
                mem_wr   = rdy_in && !stall;
                mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // Request latch, byte counter, data assembly and ready pulses
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            last_grant <= OWN_IF;
            owner      <= OWN_IF;
            base       <= 32'd0;
            wdata      <= 32'd0;
            data       <= 32'd0;
            nbytes     <= 3'd0;
            cnt        <= 3'd0;
            if_rdy     <= 1'b0;
            if_data    <= 32'd0;
            ls_rdy     <= 1'b0;
            ls_rdata   <= 32'd0;
        end else if (rdy_in) begin
            if_rdy <= 1'b0;
            ls_rdy <= 1'b0;
            if (grant_if || grant_ls) begin
                base       <= grant_if ? if_addr : ls_addr;
                nbytes     <= grant_if ? 3'd4 : width_bytes(ls_width);
                wdata      <= ls_wdata;
                owner      <= grant_if ? OWN_IF : OWN_LS;
                last_grant <= grant_if ? OWN_IF : OWN_LS;
                cnt        <= 3'd0;
                data       <= 32'd0;
            end
            // A flush drops an in-flight read; a store always runs to completion.
            if (state == ST_READ && !flush) begin
                cnt <= cnt + 3'd1;
                if (cnt != 3'd0) data <= data_nx;
                if (rd_done) begin
                    if (owner == OWN_IF) begin
                        if_rdy  <= 1'b1;
                        if_data <= data_nx;
                    end else begin
                        ls_rdy   <= 1'b1;
                        ls_rdata <= data_nx;
                    end
                end
            end
            if (state == ST_WRITE && !stall) begin
                cnt <= cnt + 3'd1;
                if (wr_done) ls_rdy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte RAM model, scoreboard queues
// filled at request time from a byte-array reference memory, a monitor that
// pops on every ready pulse, directed cycle checks and a randomized phase.
module tb_mem_arbiter;

    logic        clk_in, rst_in, rdy_in, flush;
    logic        if_en, if_rdy;
    logic [31:0] if_addr, if_data;
    logic        ls_en, ls_wr, ls_rdy;
    logic [1:0]  ls_width;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .if_en(if_en), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
        .ls_en(ls_en), .ls_wr(ls_wr), .ls_width(ls_width), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdy(ls_rdy), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          wr;
        logic [31:0] data;
    } ls_exp_t;

    logic [7:0]  ram  [0:65535];
    logic [7:0]  refm [0:65535];
    logic [31:0] exp_if [$];
    ls_exp_t     exp_ls [$];
    logic [7:0]  exp_io [$];
    logic [7:0]  io_got [$];
    int          n_cmp, n_bad, st_issued, st_acks;
    bit          rand_on;

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] t;
        case (i)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'hA0;
            32'h103: return 8'h00;
            32'h200: return 8'hFF;
            default: begin
                t = i * 37 + (i >> 7);
                return t[7:0];
            end
        endcase
    endfunction

    // Byte RAM: mem_din in cycle t+1 is the byte at mem_a in cycle t.
    // Writes into the IO window are logged instead of stored.
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_byte(i);
        mem_din = 8'd0;
        forever begin
            @(posedge clk_in);
            mem_din <= ram[mem_a[15:0]];
            if (mem_wr) begin
                if (mem_a[17:16] == 2'b11) io_got.push_back(mem_dout);
                else ram[mem_a[15:0]] <= mem_dout;
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        logic [31:0] ab;
        v = 32'd0;
        for (int b = 0; b < n; b++) begin
            ab = a + b;
            v[8*b +: 8] = refm[ab[15:0]];
        end
        return v;
    endfunction

    task automatic if_start(input logic [31:0] a);
        exp_if.push_back(ref_read(a, 4));
        if_addr = a;
        if_en   = 1'b1;
    endtask

    task automatic if_wait();
        int k;
        k = 0;
        while (!if_rdy && k < 200) begin
            step();
            k++;
        end
        if (!if_rdy) fail_msg("if_timeout", "got no if_rdy in 200 cycles, expected a pulse");
        if_en = 1'b0;
        step();
    endtask

    task automatic ls_start(input bit wr, input logic [1:0] w, input logic [31:0] a,
                            input logic [31:0] d);
        ls_exp_t     e;
        int          n;
        logic [31:0] ab;
        n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        e.wr   = wr;
        e.data = 32'd0;
        if (wr) begin
            for (int b = 0; b < n; b++) begin
                ab = a + b;
                if (ab[17:16] == 2'b11) exp_io.push_back(d[8*b +: 8]);
                else refm[ab[15:0]] = d[8*b +: 8];
            end
            st_issued++;
        end else begin
            e.data = ref_read(a, n);
        end
        exp_ls.push_back(e);
        ls_wr    = wr;
        ls_width = w;
        ls_addr  = a;
        ls_wdata = d;
        ls_en    = 1'b1;
    endtask

    task automatic ls_wait();
        int k;
        k = 0;
        while (!ls_rdy && k < 200) begin
            step();
            k++;
        end
        if (!ls_rdy) fail_msg("ls_timeout", "got no ls_rdy in 200 cycles, expected a pulse");
        ls_en = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        if_en  = 1'b0;
        ls_en  = 1'b0;
        flush  = 1'b0;
        exp_if.delete();
        exp_ls.delete();
        step();
        step();
        rst_in = 1'b1;
        step();
    endtask

    initial begin
        ls_exp_t me;
        int      seen, bad_bytes;

        n_cmp = 0; n_bad = 0; st_issued = 0; st_acks = 0; rand_on = 1'b0;
        for (int i = 0; i < 65536; i++) refm[i] = init_byte(i);
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_en = 1'b0; if_addr = 32'd0;
        ls_en = 1'b0; ls_wr = 1'b0; ls_width = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;

        // Scoreboard monitor: every ready pulse pops and checks one entry.
        fork
            forever begin
                @(negedge clk_in);
                if (rst_in) begin
                    if (if_rdy && ls_rdy) fail_msg("both_rdy", "got if_rdy and ls_rdy together, expected at most one");
                    if (if_rdy) begin
                        if (exp_if.size() == 0) fail_msg("unexpected_if_rdy", "got a pulse, expected none");
                        else chk("if_data", if_data, exp_if.pop_front());
                    end
                    if (ls_rdy) begin
                        if (exp_ls.size() == 0) fail_msg("unexpected_ls_rdy", "got a pulse, expected none");
                        else begin
                            me = exp_ls.pop_front();
                            if (me.wr) st_acks++;
                            else chk("ls_rdata", ls_rdata, me.data);
                        end
                    end
                end
            end
        join_none

        // Reset state
        step();
        chk("rst_if_rdy", if_rdy, 0);
        chk("rst_ls_rdy", ls_rdy, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        rst_in = 1'b1;
        step();

        // Single fetch
        if_start(32'h100);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("fetch_mem_a", mem_a, 32'h100 + c - 1);
            chk("fetch_mem_wr", mem_wr, 0);
        end
        step();
        chk("fetch_rdy_c5", if_rdy, 0);
        step();
        chk("fetch_rdy_c6", if_rdy, 1);
        chk("fetch_data_c6", if_data, 32'h00A00513);
        if_wait();

        // Contention right after reset: LSB first, fetch right after
        do_reset();
        if_start(32'h100);
        ls_start(1'b0, 2'd0, 32'h200, 32'd0);
        step();
        chk("cont_ls_first", mem_a, 32'h200);
        step();
        step();
        chk("cont_ls_rdy_c3", ls_rdy, 1);
        chk("cont_ls_rdata", ls_rdata, 32'h0000_00FF);
        ls_wait();
        step();
        chk("cont_fetch_next", mem_a, 32'h100);
        if_wait();

        // Store half across a page boundary
        ls_start(1'b1, 2'd1, 32'h1FFF, 32'h0000_BEEF);
        step();
        chk("sh_a1", mem_a, 32'h1FFF);
        chk("sh_d1", mem_dout, 8'hEF);
        chk("sh_wr1", mem_wr, 1);
        step();
        chk("sh_a2", mem_a, 32'h2000);
        chk("sh_d2", mem_dout, 8'hBE);
        step();
        chk("sh_rdy_c3", ls_rdy, 1);
        ls_wait();

        // IO stall
        io_buffer_full = 1'b1;
        ls_start(1'b1, 2'd0, 32'h30000, 32'h0000_00A5);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("io_stall_wr", mem_wr, 0);
        end
        step();
        io_buffer_full = 1'b0;
        #1;
        chk("io_wr", mem_wr, 1);
        chk("io_a", mem_a, 32'h30000);
        chk("io_d", mem_dout, 8'hA5);
        step();
        chk("io_rdy", ls_rdy, 1);
        ls_wait();

        // Flush in IDLE suppresses that cycle's grant only
        if_start(32'h104);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_idle_nogrant", mem_a, 0);
        step();
        chk("flush_idle_then_grant", mem_a, 32'h104);
        if_wait();

        // Flush mid-fetch
        if_start(32'h100);
        step(); step(); step();
        flush = 1'b1;
        if_en = 1'b0;
        exp_if.delete();
        step();
        flush = 1'b0;
        chk("flush_fetch_idle", mem_a, 0);
        seen = 0;
        repeat (6) begin
            step();
            if (if_rdy) seen++;
        end
        chk("flush_fetch_no_rdy", seen, 0);

        // Flush during a word store: store still completes
        ls_start(1'b1, 2'd2, 32'h300, 32'h1234_5678);
        for (int c = 1; c <= 4; c++) begin
            step();
            flush = (c == 2);
            chk("fst_wr", mem_wr, 1);
            chk("fst_a", mem_a, 32'h300 + c - 1);
        end
        step();
        chk("fst_rdy", ls_rdy, 1);
        ls_wait();
        ls_start(1'b0, 2'd2, 32'h300, 32'd0);
        ls_wait();

        // rdy_in low freezes and gates the write strobe
        ls_start(1'b1, 2'd0, 32'h400, 32'h0000_005A);
        step();
        rdy_in = 1'b0;
        #1;
        chk("freeze_no_wr", mem_wr, 0);
        step();
        rdy_in = 1'b1;
        #1;
        chk("freeze_resume_wr", mem_wr, 1);
        chk("freeze_resume_a", mem_a, 32'h400);
        step();
        chk("freeze_rdy", ls_rdy, 1);
        ls_wait();
        ls_start(1'b0, 2'd0, 32'h400, 32'd0);
        ls_wait();

        // 32-bit address wrap
        ls_start(1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0);
        step(); step(); step();
        chk("wrap_a", mem_a, 32'h0);
        ls_wait();

        // Asynchronous reset mid-read, then a fresh fetch
        if_start(32'h0);
        step(); step(); step();
        #3;
        rst_in = 1'b0;
        #1;
        chk("arst_mem_a", mem_a, 0);
        chk("arst_if_data", if_data, 0);
        chk("arst_ls_rdata", ls_rdata, 0);
        chk("arst_if_rdy", if_rdy, 0);
        if_en = 1'b0;
        exp_if.delete();
        exp_ls.delete();
        step(); step();
        rst_in = 1'b1;
        step();
        if_start(32'h0);
        if_wait();

        // Randomized concurrent traffic
        rand_on = 1'b1;
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 60; i++) begin
                            repeat ($urandom_range(0, 3)) step();
                            if_start(32'h8000 + ($urandom_range(0, 32'hFFF) << 2));
                            if_wait();
                        end
                    end
                    begin
                        for (int i = 0; i < 80; i++) begin
                            int kind;
                            repeat ($urandom_range(0, 3)) step();
                            kind = $urandom_range(0, 9);
                            if (kind == 0)
                                ls_start(1'b1, 2'd0, 32'h30000 | $urandom_range(0, 255), $urandom);
                            else
                                ls_start(kind < 5, 2'($urandom_range(0, 2)),
                                         32'($urandom_range(0, 32'h3FF)), $urandom);
                            ls_wait();
                        end
                    end
                join
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    step();
                    io_buffer_full = ($urandom_range(0, 3) == 0);
                end
                io_buffer_full = 1'b0;
            end
        join

        repeat (4) step();
        chk("if_queue_empty", exp_if.size(), 0);
        chk("ls_queue_empty", exp_ls.size(), 0);
        chk("store_acks", st_acks, st_issued);
        chk("io_count", io_got.size(), exp_io.size());
        for (int i = 0; i < exp_io.size() && i < io_got.size(); i++)
            chk("io_byte", io_got[i], exp_io[i]);
        bad_bytes = 0;
        for (int i = 0; i < 65536; i++)
            if (ram[i] !== refm[i]) bad_bytes++;
        chk("ram_contents", bad_bytes, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide RAM/IO port.
- Arbitrates between two requesters:
  - instruction fetch from the decoder: word reads only;
  - load/store buffer: byte/half/word reads and writes.
- Sequences each request as consecutive single-byte RAM cycles, assembles or splits little-endian data, and pulses a one-cycle ready back to the requester.

Parameters:
- IO_BASE, 32'h30000, addresses with addr[17:16]==2'b11 are IO; writes to IO honour io_buffer_full.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; low freezes all state
- flush  in  1  mispredict flush from the reorder buffer
- if_en  in  1  fetch request (level, held until if_rdy)
- if_addr  in  32  fetch address (word)
- if_rdy  out  1  one-cycle pulse, fetch data valid
- if_data  out  32  fetched instruction
- ls_en  in  1  LSB request (level, held until ls_rdy)
- ls_wr  in  1  1 = store, 0 = load
- ls_width  in  2  0 = byte, 1 = half, 2 = word (`MEM_W_*)
- ls_addr  in  32  LSB address
- ls_wdata  in  32  store data; low bytes used
- ls_rdy  out  1  one-cycle pulse, load data valid or store done
- ls_rdata  out  32  load data, zero-extended (LSB sign-extends)
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset (rst_in low, asynchronous):
  - state IDLE, last_grant = fetch;
  - counters and data registers cleared;
  - every output 0.
- rdy_in low: no register changes; mem_wr driven 0.
- RAM model: mem_din in cycle t+1 is the byte addressed by mem_a in cycle t.
- States: IDLE, READ, WRITE.
- IDLE:
  - Only one request: grant it.
  - Both if_en and ls_en: grant the requester not granted last (last_grant toggle). The first contention after reset goes to the LSB.
  - On grant: latch address, width (fetch = word, N = 4 bytes; else N = 1/2/4), wdata and owner; cnt <= 0; go to READ or WRITE.
  - While IDLE: mem_wr = 0, mem_a = 0.
- READ:
  - Cycles 1..N after grant: mem_a = base + cnt, mem_wr = 0.
  - Byte k is captured into data[8k+7:8k] one cycle after it is addressed.
  - Owner rdy pulses in cycle N+2 after grant, with data registered on the same edge. For a word: grant at edge 0, if_rdy high in cycle 6.
  - State returns to IDLE on the pulse edge, so a new grant is possible the cycle after the pulse.
- WRITE:
  - Cycles 1..N: mem_wr = 1, mem_a = base + cnt, mem_dout = wdata[8cnt+7:8cnt].
  - IO stall: if the address is in IO and io_buffer_full = 1, mem_wr = 0 and cnt holds until io_buffer_full drops.
  - ls_rdy pulses in the cycle after the last byte is written; state returns to IDLE.
- Address arithmetic: 32-bit wrap on base + cnt; no alignment check, since unaligned accesses are issued byte by byte.
- Flush:
  - In-flight fetch or load is aborted: IDLE next cycle, no rdy pulse, partial data discarded.
  - In-flight store is committed and completes normally, including its ls_rdy pulse.
  - A flush in IDLE has no effect, and grant arbitration that cycle is suppressed.
- Rdy pulses are exactly one cycle. if_rdy and ls_rdy are never high together.
- Requesters must hold en/addr/data stable until their rdy. Deasserting en mid-transaction (other than via flush) is illegal.

Decomposition:
- params.v gains:
  - `MEM_W_BYTE / `MEM_W_HALF / `MEM_W_WORD;
  - `MEM_STATE_WIDTH plus IDLE/READ/WRITE codes;
  - IO_BASE.
- No sub-module is needed; byte assembly is inline shift logic.

Test Plan:
- Single fetch: if_addr = 0x100, RAM[0x100..0x103] = 13 05 A0 00 -> mem_a 0x100..0x103 in cycles 1-4; if_rdy in cycle 6 with if_data = 0x00A00513.
- Contention: if_en and ls_en (load byte 0x200, RAM = 0xFF) asserted together after reset -> LSB first, ls_rdata = 0x000000FF; fetch granted in the cycle after ls_rdy.
- Store half: ls_wr = 1, width = 1, addr 0x1FFF, wdata 0xBEEF -> cycle 1 mem_a = 0x1FFF, mem_dout = 0xEF; cycle 2 mem_a = 0x2000, mem_dout = 0xBE; ls_rdy in cycle 3.
- IO stall: byte store to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr = 0 for those 3 cycles, then a single write of the byte, then ls_rdy.
- Flush mid-fetch: flush in cycle 3 of a fetch -> no if_rdy, IDLE next cycle; a flush during a word store still yields 4 writes and ls_rdy.
- Reset mid-READ: rst_in low asynchronously -> all outputs 0 immediately; after release, a fresh fetch from 0 completes correctly.
